loop_uhat_mul_arbiter: RTL
==========================

Name: loop_uhat_mul_arbiter

Overview:
- Shares one pipelined unsigned multiplier (87b x 6b -> 93b, 4-cycle latency, clock-enable stall) between NUM_REQ requesters in the loop_uhat datapath.
- Round-robin issue, one operation per cycle.
- Carries a requester tag alongside the multiplier pipeline and returns each product to its owner.
- Whole pipeline stalls via multiplier ce when the owner of the output result is not ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIN0_WIDTH, 87, width of operand 0.
- DIN1_WIDTH, 6, width of operand 1.
- DOUT_WIDTH, 93, width of the product.
- MUL_LATENCY, 4, ce-qualified clock edges from operands presented to product valid at the multiplier dout.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant; the operation transfers when req_valid[i] and req_ready[i] are both high.
- req_din0  in  NUM_REQ*DIN0_WIDTH  packed operand 0; requester i at slice i.
- req_din1  in  NUM_REQ*DIN1_WIDTH  packed operand 1; requester i at slice i.
- rsp_valid  out  NUM_REQ  one-hot: result available for requester i.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_dout  out  DOUT_WIDTH  product (shared bus, qualified by rsp_valid).
- mul_ce  out  1  multiplier clock enable.
- mul_din0  out  DIN0_WIDTH  multiplier operand 0.
- mul_din1  out  DIN1_WIDTH  multiplier operand 1.
- mul_dout  in  DOUT_WIDTH  multiplier product.
- busy  out  1  any operation in flight.

Behaviour:
- Reset (reset_n low, async):
  - tag valid bits cleared; rr pointer = 0.
  - req_ready = 0, rsp_valid = 0, busy = 0, mul_ce = 1.
  - In-flight results are discarded. The multiplier has no reset; its stale data is masked by the cleared tags.
- Tag pipeline: MUL_LATENCY stages of {valid, id}. Shifts only when mul_ce = 1. Stage 0 loads {issue, grant_id}.
- Output stage:
  - out_v = last-stage valid; out_id = last-stage id.
  - rsp_valid = out_v ? onehot(out_id) : 0.
  - rsp_dout = mul_dout, passed through combinationally.
- Stall:
  - mul_ce = !(out_v && !rsp_ready[out_id]), combinational.
  - When stalled, no grant is issued, the tag pipeline holds, and rsp_valid/rsp_dout hold stable.
- Arbitration:
  - When mul_ce = 1 and any req_valid is high, grant the first requester with req_valid set, searching upward from the rr pointer with wrap from NUM_REQ-1 to 0.
  - req_ready = onehot(grant) and is combinational from req_valid. It is never high while stalled or for a requester with req_valid low.
  - mul_din0/mul_din1 = granted requester's operands; all-zero when there is no issue.
  - On issue, the rr pointer becomes grant_id+1 mod NUM_REQ. Otherwise the pointer holds.
- Latency: an operation issued in cycle t appears on rsp_valid in cycle t+MUL_LATENCY when no stall occurs; each stall cycle adds 1.
- Throughput: 1 operation/cycle sustained with all rsp_ready high.
- Simultaneous events: in the same cycle, a result may be accepted and a new operation issued, including by the same requester.
- busy = OR of all tag valid bits.
- Arithmetic: unsigned. The block performs no width conversion; DOUT_WIDTH = DIN0_WIDTH + DIN1_WIDTH.

Optional Feature:
- Macro: LOOP_UHAT_MUL_ARB_PERF_EN.
- When defined, adds these outputs:
  - perf_issue_cnt (32b): operations issued.
  - perf_stall_cnt (32b): cycles with mul_ce = 0.
  - perf_idle_cnt (32b): cycles with mul_ce = 1 and no issue.
- Counters are cleared by reset_n, saturate at all-ones, and increment synchronously.
- When the macro is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single operation: requester 2 issues din0 = 5, din1 = 7 at cycle 10 -> rsp_valid = 4'b0100 with rsp_dout = 35 at cycle 14; busy high for cycles 11-14.
- All four requesters valid from cycle 0 with pointer 0, din0 = i+1, din1 = 3 -> grants 0, 1, 2, 3 in cycles 0-3; results 3, 6, 9, 12 in cycles 4-7 to the matching rsp_valid bit.
- Backpressure: requester 1's rsp_ready held low for 3 cycles when its result arrives -> mul_ce = 0 for 3 cycles; no req_ready; rsp_dout stable; later results shift by 3 cycles with none lost.
- Fairness: requesters 0 and 3 continuously valid -> grants alternate 0, 3, 0, 3; neither is starved.
- Max width: din0 = 2^87-1, din1 = 63 -> rsp_dout = 63*(2^87-1) with no truncation.
- Reset mid-flight: assert reset_n low for 1 cycle while 3 operations are in flight -> no rsp_valid afterwards and busy = 0; the next request completes with normal 4-cycle latency.

Source files
------------

// File: rtl/loop_uhat_mul_arbiter_if.sv
// Bus between the loop_uhat multiplier arbiter, its requesters and the shared multiplier.
// The slave modport is the arbiter's view; master is the environment's view.
interface loop_uhat_mul_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DIN0_WIDTH = 87,
    parameter int unsigned DIN1_WIDTH = 6,
    parameter int unsigned DOUT_WIDTH = 93
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
    logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DOUT_WIDTH-1:0]         rsp_dout;
    logic                          mul_ce;
    logic [DIN0_WIDTH-1:0]         mul_din0;
    logic [DIN1_WIDTH-1:0]         mul_din1;
    logic [DOUT_WIDTH-1:0]         mul_dout;
    logic                          busy;

    modport slave (
        input  req_valid, req_din0, req_din1, rsp_ready, mul_dout,
        output req_ready, rsp_valid, rsp_dout, mul_ce, mul_din0, mul_din1, busy
    );

    modport master (
        output req_valid, req_din0, req_din1, rsp_ready, mul_dout,
        input  req_ready, rsp_valid, rsp_dout, mul_ce, mul_din0, mul_din1, busy
    );
endinterface

// File: rtl/loop_uhat_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters, tagging
// each op with its owner. Optional perf counters: define LOOP_UHAT_MUL_ARB_PERF_EN.
module loop_uhat_mul_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DIN0_WIDTH  = 87,
    parameter int unsigned DIN1_WIDTH  = 6,
    parameter int unsigned DOUT_WIDTH  = 93,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    loop_uhat_mul_arbiter_if.slave        io_mul_arb
`ifdef LOOP_UHAT_MUL_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_stall_cnt,
    output logic [31:0]                   perf_idle_cnt
`endif
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [MUL_LATENCY-1:0] r_tag_v;
    logic [IdW-1:0]         r_tag_id [MUL_LATENCY];
    logic [IdW-1:0]         r_rr_ptr;

    logic                   w_out_v;
    logic [IdW-1:0]         w_out_id;
    logic                   w_mul_ce;
    logic                   w_issue;
    logic [IdW-1:0]         w_grant_id;
    logic [IdW-1:0]         w_idx;
    logic [DIN0_WIDTH-1:0]  w_din0 [NUM_REQ];
    logic [DIN1_WIDTH-1:0]  w_din1 [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_din0[g] = io_mul_arb.req_din0[g*DIN0_WIDTH +: DIN0_WIDTH];
        assign w_din1[g] = io_mul_arb.req_din1[g*DIN1_WIDTH +: DIN1_WIDTH];
    end

    assign w_out_v  = r_tag_v[MUL_LATENCY-1];
    assign w_out_id = r_tag_id[MUL_LATENCY-1];
    // Freeze the whole pipe while the owner of the finished product cannot take it.
    assign w_mul_ce = !(w_out_v && !io_mul_arb.rsp_ready[w_out_id]);

    always_comb begin
        w_issue    = 1'b0;
        w_grant_id = '0;
        w_idx      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = IdW'((32'(r_rr_ptr) + k) % NUM_REQ);
            // reset_n gating keeps req_ready low while reset is held.
            if (reset_n && w_mul_ce && !w_issue && io_mul_arb.req_valid[w_idx]) begin
                w_issue    = 1'b1;
                w_grant_id = w_idx;
            end
        end
    end

    always_comb begin
        io_mul_arb.req_ready = '0;
        io_mul_arb.mul_din0  = '0;
        io_mul_arb.mul_din1  = '0;
        if (w_issue) begin
            io_mul_arb.req_ready[w_grant_id] = 1'b1;
            io_mul_arb.mul_din0              = w_din0[w_grant_id];
            io_mul_arb.mul_din1              = w_din1[w_grant_id];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '{default: '0};
            r_rr_ptr <= '0;
        end else if (w_mul_ce) begin
            r_tag_v     <= {r_tag_v[MUL_LATENCY-2:0], w_issue};
            r_tag_id[0] <= w_grant_id;
            for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
            if (w_issue) begin
                r_rr_ptr <= (w_grant_id == IdW'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
            end
        end
    end

    always_comb begin
        io_mul_arb.rsp_valid = '0;
        if (w_out_v) begin
            io_mul_arb.rsp_valid[w_out_id] = 1'b1;
        end
    end

    assign io_mul_arb.rsp_dout = DOUT_WIDTH'(io_mul_arb.mul_dout);
    assign io_mul_arb.mul_ce   = w_mul_ce;
    assign io_mul_arb.busy     = |r_tag_v;

`ifdef LOOP_UHAT_MUL_ARB_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_idle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
            r_perf_idle  <= '0;
        end else begin
            if (w_issue && (r_perf_issue != '1)) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
            if (!w_mul_ce && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_mul_ce && !w_issue && (r_perf_idle != '1)) begin
                r_perf_idle <= r_perf_idle + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = r_perf_issue;
    assign perf_stall_cnt = r_perf_stall;
    assign perf_idle_cnt  = r_perf_idle;
`endif
endmodule
